// File: rtl/ncpu32k_dbus_arbiter.sv
// Two-master data-bus arbiter: IFU (m0, read-only) and MU (m1) share one memory port.
// Round-robin command grant with stall lock, one outstanding transaction, response routed to owner.
module ncpu32k_dbus_arbiter #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int ENABLE_BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_cmd_valid,
  output logic            m0_cmd_ready,
  input  logic [AW-1:0]   m0_cmd_addr,
  output logic            m0_valid,
  input  logic            m0_ready,
  input  logic            m1_cmd_valid,
  output logic            m1_cmd_ready,
  input  logic [AW-1:0]   m1_cmd_addr,
  input  logic [DW/8-1:0] m1_cmd_we_msk,
  input  logic [DW-1:0]   m1_din,
  output logic            m1_valid,
  input  logic            m1_ready,
  output logic [DW-1:0]   m_dout,
  output logic            mem_cmd_valid,
  input  logic            mem_cmd_ready,
  output logic [AW-1:0]   mem_cmd_addr,
  output logic [DW/8-1:0] mem_cmd_we_msk,
  output logic [DW-1:0]   mem_din,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [DW-1:0]   mem_dout
);

  typedef enum logic {S_IDLE, S_WAIT_RSP} state_t;

  localparam logic BYP = (ENABLE_BYPASS != 0);

  state_t r_state, w_state_nxt;
  logic   r_owner, w_owner_nxt;
  logic   r_last_grant, w_last_grant_nxt;
  logic   r_lock_v, w_lock_v_nxt;
  logic   r_lock_id, w_lock_id_nxt;

  logic w_grant, w_sel, w_open, w_own_ready, w_rsp_hs, w_cmd_hs;

  assign w_own_ready = r_owner ? m1_ready : m0_ready;
  assign mem_ready   = (r_state == S_WAIT_RSP) & w_own_ready;
  assign w_rsp_hs    = mem_valid & mem_ready;
  // rst_n gating keeps every handshake output low while reset is asserted.
  assign w_open      = rst_n & ((r_state == S_IDLE) | (BYP & w_rsp_hs));

  always_comb begin
    w_grant = r_last_grant;
    if (r_lock_v)
      w_grant = r_lock_id;
    else if (m0_cmd_valid ^ m1_cmd_valid)
      w_grant = m1_cmd_valid;
    else if (m0_cmd_valid & m1_cmd_valid)
      w_grant = ~r_last_grant;
  end

  // Data muxes fall back to m0 while in reset.
  assign w_sel          = rst_n & w_grant;
  assign mem_cmd_valid  = w_open & (w_sel ? m1_cmd_valid : m0_cmd_valid);
  assign m0_cmd_ready   = w_open & ~w_sel & mem_cmd_ready;
  assign m1_cmd_ready   = w_open & w_sel & mem_cmd_ready;
  assign mem_cmd_addr   = w_sel ? m1_cmd_addr : m0_cmd_addr;
  assign mem_cmd_we_msk = w_sel ? m1_cmd_we_msk : '0;
  assign mem_din        = w_sel ? m1_din : '0;
  assign w_cmd_hs       = mem_cmd_valid & mem_cmd_ready;

  assign m0_valid = (r_state == S_WAIT_RSP) & ~r_owner & mem_valid;
  assign m1_valid = (r_state == S_WAIT_RSP) & r_owner & mem_valid;
  assign m_dout   = mem_dout;

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_grant_nxt = r_last_grant;
    w_lock_v_nxt     = r_lock_v;
    w_lock_id_nxt    = r_lock_id;
    if (w_cmd_hs) begin
      w_state_nxt      = S_WAIT_RSP;
      w_owner_nxt      = w_grant;
      w_last_grant_nxt = w_grant;
      w_lock_v_nxt     = 1'b0;
    end else begin
      if (mem_cmd_valid) begin
        w_lock_v_nxt  = 1'b1;
        w_lock_id_nxt = w_grant;
      end
      if (w_rsp_hs)
        w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_lock_v     <= 1'b0;
      r_lock_id    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_lock_v     <= w_lock_v_nxt;
      r_lock_id    <= w_lock_id_nxt;
    end
  end

endmodule

// File: tb/tb_ncpu32k_dbus_arbiter.sv
// Bench for ncpu32k_dbus_arbiter: bypass (index 0) and non-bypass (index 1) instances share stimulus,
// each checked every cycle against a transaction-level model, plus directed literal scenarios.
module tb_ncpu32k_dbus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0v, m0r, m1v, m1r, mcr, mv;
  logic [31:0] m0a, m1a, m1d, md;
  logic [3:0]  m1m;

  wire [1:0]       o_m0cr, o_m0v, o_m1cr, o_m1v, o_mcv, o_mr;
  wire [1:0][31:0] o_addr, o_din, o_dout;
  wire [1:0][3:0]  o_msk;

  int checks = 0;
  int errors = 0;
  int cnt_hs [2];

  always #5 clk = ~clk;

  ncpu32k_dbus_arbiter #(.AW(32), .DW(32), .ENABLE_BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n),
    .m0_cmd_valid(m0v), .m0_cmd_ready(o_m0cr[0]), .m0_cmd_addr(m0a),
    .m0_valid(o_m0v[0]), .m0_ready(m0r),
    .m1_cmd_valid(m1v), .m1_cmd_ready(o_m1cr[0]), .m1_cmd_addr(m1a),
    .m1_cmd_we_msk(m1m), .m1_din(m1d), .m1_valid(o_m1v[0]), .m1_ready(m1r),
    .m_dout(o_dout[0]), .mem_cmd_valid(o_mcv[0]), .mem_cmd_ready(mcr),
    .mem_cmd_addr(o_addr[0]), .mem_cmd_we_msk(o_msk[0]), .mem_din(o_din[0]),
    .mem_valid(mv), .mem_ready(o_mr[0]), .mem_dout(md));

  ncpu32k_dbus_arbiter #(.AW(32), .DW(32), .ENABLE_BYPASS(0)) u_nobyp (
    .clk(clk), .rst_n(rst_n),
    .m0_cmd_valid(m0v), .m0_cmd_ready(o_m0cr[1]), .m0_cmd_addr(m0a),
    .m0_valid(o_m0v[1]), .m0_ready(m0r),
    .m1_cmd_valid(m1v), .m1_cmd_ready(o_m1cr[1]), .m1_cmd_addr(m1a),
    .m1_cmd_we_msk(m1m), .m1_din(m1d), .m1_valid(o_m1v[1]), .m1_ready(m1r),
    .m_dout(o_dout[1]), .mem_cmd_valid(o_mcv[1]), .mem_cmd_ready(mcr),
    .mem_cmd_addr(o_addr[1]), .mem_cmd_we_msk(o_msk[1]), .mem_din(o_din[1]),
    .mem_valid(mv), .mem_ready(o_mr[1]), .mem_dout(md));

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  // Transaction-level model: a pending flag with its owner, the master that wins the next tie,
  // and an optional master pinned by a stalled command.
  bit pend [2], own [2], tie_win [2], pinned [2], pin_id [2];
  bit g, open, orr, e_mr, rsp, e_mcv;

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        pend[k] = 0; own[k] = 0; tie_win[k] = 0; pinned[k] = 0; pin_id[k] = 0;
      end else begin
        orr  = own[k] ? m1r : m0r;
        e_mr = pend[k] && orr;
        rsp  = e_mr && mv;
        open = !pend[k] || (k == 0 && rsp);
        if (pinned[k])       g = pin_id[k];
        else if (m0v && m1v) g = tie_win[k];
        else if (m0v)        g = 0;
        else if (m1v)        g = 1;
        else                 g = !tie_win[k];
        e_mcv = open && (g ? m1v : m0v);
        chk("mem_cmd_valid", k, o_mcv[k], e_mcv);
        chk("m0_cmd_ready", k, o_m0cr[k], open && !g && mcr);
        chk("m1_cmd_ready", k, o_m1cr[k], open && g && mcr);
        chk("m0_valid", k, o_m0v[k], pend[k] && !own[k] && mv);
        chk("m1_valid", k, o_m1v[k], pend[k] && own[k] && mv);
        chk("mem_ready", k, o_mr[k], e_mr);
        chk("mem_cmd_addr", k, o_addr[k], g ? m1a : m0a);
        chk("mem_cmd_we_msk", k, o_msk[k], g ? m1m : 4'h0);
        chk("mem_din", k, o_din[k], g ? m1d : 32'h0);
        chk("m_dout", k, o_dout[k], md);
        if (e_mcv && mcr) begin
          pend[k] = 1; own[k] = g; tie_win[k] = !g; pinned[k] = 0;
        end else begin
          if (e_mcv) begin pinned[k] = 1; pin_id[k] = g; end
          if (rsp) pend[k] = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    m0v = 0; m0r = 0; m1v = 0; m1r = 0; mcr = 0; mv = 0;
    m0a = 32'h44; m1a = 32'h88; m1d = 32'h0; md = 32'h0; m1m = 4'h0;
  endtask

  initial begin
    rst_n = 0;
    idle_in();
    #3;
    for (int k = 0; k < 2; k++) begin
      chk("rst mem_cmd_valid", k, o_mcv[k], 0);
      chk("rst mem_ready", k, o_mr[k], 0);
      chk("rst mem_cmd_addr", k, o_addr[k], 32'h44);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Single m1 store, response two cycles later.
    step(); m1v = 1; m1a = 32'h100; m1m = 4'b1100; m1d = 32'hAAAA5555; mcr = 1;
    #3;
    for (int k = 0; k < 2; k++) begin
      chk("st m1_cmd_ready", k, o_m1cr[k], 1);
      chk("st m0_cmd_ready", k, o_m0cr[k], 0);
      chk("st addr", k, o_addr[k], 32'h100);
      chk("st msk", k, o_msk[k], 4'hC);
      chk("st din", k, o_din[k], 32'hAAAA5555);
    end
    step(); idle_in(); m1r = 1;
    #3 for (int k = 0; k < 2; k++) chk("st early m1_valid", k, o_m1v[k], 0);
    step(); mv = 1; md = 32'h12345678;
    #3;
    for (int k = 0; k < 2; k++) begin
      chk("st rsp m1_valid", k, o_m1v[k], 1);
      chk("st rsp m0_valid", k, o_m0v[k], 0);
    end
    step(); idle_in();
    #3 for (int k = 0; k < 2; k++) chk("st done m1_valid", k, o_m1v[k], 0);

    // One m0 fetch so the next tie would favour m1.
    step(); m0v = 1; m0a = 32'h200; mcr = 1;
    #3 for (int k = 0; k < 2; k++) chk("f m0_cmd_ready", k, o_m0cr[k], 1);
    step(); idle_in(); mv = 1; m0r = 1; md = 32'h1111;
    #3 for (int k = 0; k < 2; k++) chk("f m0_valid", k, o_m0v[k], 1);
    step(); idle_in();

    // Stalled m0 keeps the grant although m1 joins.
    step(); m0v = 1; m0a = 32'h300; mcr = 0;
    step(); m1v = 1; m1a = 32'h400;
    #3 for (int k = 0; k < 2; k++) chk("lock addr", k, o_addr[k], 32'h300);
    step();
    #3 for (int k = 0; k < 2; k++) chk("lock m1_cmd_ready", k, o_m1cr[k], 0);
    step(); mcr = 1;
    #3;
    for (int k = 0; k < 2; k++) begin
      chk("lock m0_cmd_ready", k, o_m0cr[k], 1);
      chk("lock m1_cmd_ready hs", k, o_m1cr[k], 0);
    end
    step(); m0v = 0; mv = 1; m0r = 1;
    #3 for (int k = 0; k < 2; k++) chk("bypass m1_cmd_ready", k, o_m1cr[k], k == 0);
    step(); mv = 0; m0r = 0;

    // m1 load held off by m1_ready=0 while m0 keeps asking.
    step(); m1v = 0; m0v = 1; m0a = 32'h500; mv = 1; m1r = 0; md = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      #3;
      for (int k = 0; k < 2; k++) begin
        chk("bp mem_ready", k, o_mr[k], 0);
        chk("bp m0_cmd_ready", k, o_m0cr[k], 0);
      end
    end
    step(); m1r = 1;
    #3;
    for (int k = 0; k < 2; k++) begin
      chk("bp m1_valid", k, o_m1v[k], 1);
      chk("bp dout", k, o_dout[k], 32'hDEADBEEF);
      chk("bp bypass m0_cmd_ready", k, o_m0cr[k], k == 0);
    end
    step(); idle_in(); mv = 1; m0r = 1;
    #3 for (int k = 0; k < 2; k++) chk("stray m1_valid", k, o_m1v[k], 0);
    step(); idle_in();

    // Lock m1 by a stall, then reset asynchronously mid-cycle.
    step(); m1v = 1; mcr = 0;
    step(); m0v = 1; mv = 1; m0r = 1; m1r = 1; mcr = 1;
    #2 rst_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("arst mem_cmd_valid", k, o_mcv[k], 0);
      chk("arst m0_cmd_ready", k, o_m0cr[k], 0);
      chk("arst m1_cmd_ready", k, o_m1cr[k], 0);
      chk("arst m0_valid", k, o_m0v[k], 0);
      chk("arst m1_valid", k, o_m1v[k], 0);
      chk("arst mem_ready", k, o_mr[k], 0);
      chk("arst addr", k, o_addr[k], 32'h44);
    end
    step(); rst_n = 1;

    // Both masters always requesting, memory always ready and responding.
    cnt_hs[0] = 0; cnt_hs[1] = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step();
      #3;
      chk("rr m0_cmd_ready", 0, o_m0cr[0], (i % 2) == 0);
      chk("rr m1_cmd_ready", 0, o_m1cr[0], (i % 2) == 1);
      chk("rr m0_cmd_ready", 1, o_m0cr[1], (i % 4) == 0);
      chk("rr m1_cmd_ready", 1, o_m1cr[1], (i % 4) == 2);
      for (int k = 0; k < 2; k++) if (o_mcv[k] && mcr) cnt_hs[k]++;
    end
    chk("rr issue count", 0, cnt_hs[0], 12);
    chk("rr issue count", 1, cnt_hs[1], 6);

    // Randomized traffic, occasional asynchronous reset.
    for (int i = 0; i < 4000; i++) begin
      step();
      rst_n = ($urandom_range(0, 299) != 0);
      m0v = ($urandom_range(0, 9) < 6);
      m1v = ($urandom_range(0, 9) < 6);
      m0r = ($urandom_range(0, 9) < 7);
      m1r = ($urandom_range(0, 9) < 7);
      mcr = ($urandom_range(0, 9) < 7);
      mv  = ($urandom_range(0, 9) < 5);
      m0a = $urandom; m1a = $urandom; m1d = $urandom; md = $urandom;
      m1m = 4'($urandom);
    end
    step(); rst_n = 1;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
